// File: rtl/lk_tile_accumulator.sv
// lk_tile_accumulator
//   Lucas-Kanade structure-tensor accumulator. Takes the raster stream of
//   signed gradients (Ix, Iy, It), forms the five per-pixel products and sums
//   them over non-overlapping TILE x TILE tiles. It emits one record per tile:
//   Sxx, Syy, Sxy, Sxt, Syt.
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     frame_sync           1-cycle start-of-frame pulse. It clears the counters
//                          and drops any beat already in flight.
//     grad_x/y/t           signed gradients, qualified by grad_valid
//     sum_xx..sum_yt       tile sums, held between strobes
//     tile_x, tile_y       tile coordinates of the current record
//     tile_valid           1-cycle record strobe
//     frame_done           strobes together with the record of the last tile
//
//   Pipeline
//     S1: the five products, the pixel coordinates and a valid bit.
//     S2: read-modify-write of the per-column accumulator entry, plus record
//         output on the last pixel of a tile.
//   Accumulator writes are registered and land one cycle after S2. S2 therefore
//   forwards the pending write when it reads the same tile column.
module lk_tile_accumulator #(
    parameter int GRAD_WIDTH = 12,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int TILE       = 8,
    localparam int ACC_WIDTH = 2*GRAD_WIDTH + 2*$clog2(TILE),
    localparam int TX_W      = $clog2(IMG_WIDTH/TILE),
    localparam int TY_W      = $clog2(IMG_HEIGHT/TILE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_sync,
    input  logic signed [GRAD_WIDTH-1:0] grad_x,
    input  logic signed [GRAD_WIDTH-1:0] grad_y,
    input  logic signed [GRAD_WIDTH-1:0] grad_t,
    input  logic                        grad_valid,
    output logic signed [ACC_WIDTH-1:0] sum_xx,
    output logic signed [ACC_WIDTH-1:0] sum_yy,
    output logic signed [ACC_WIDTH-1:0] sum_xy,
    output logic signed [ACC_WIDTH-1:0] sum_xt,
    output logic signed [ACC_WIDTH-1:0] sum_yt,
    output logic [TX_W-1:0]             tile_x,
    output logic [TY_W-1:0]             tile_y,
    output logic                        tile_valid,
    output logic                        frame_done
);

    localparam int NS      = 5;              // lanes: 0 xx, 1 yy, 2 xy, 3 xt, 4 yt
    localparam int PW      = 2*GRAD_WIDTH;
    localparam int TB      = $clog2(TILE);
    localparam int COL_W   = $clog2(IMG_WIDTH);
    localparam int ROW_W   = $clog2(IMG_HEIGHT);
    localparam int TILES_X = IMG_WIDTH/TILE;
    localparam int TILES_Y = IMG_HEIGHT/TILE;

    typedef logic [NS-1:0][ACC_WIDTH-1:0] sums_t;

    // ---------------- pixel counters ----------------
    logic [COL_W-1:0] col, col_cur;
    logic [ROW_W-1:0] row, row_cur;

    // A beat that arrives together with frame_sync is pixel (0,0) of the new frame.
    always_comb begin
        col_cur = frame_sync ? '0 : col;
        row_cur = frame_sync ? '0 : row;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (grad_valid) begin
            if (col_cur == COL_W'(IMG_WIDTH-1)) begin
                col <= '0;
                row <= (row_cur == ROW_W'(IMG_HEIGHT-1)) ? '0 : row_cur + ROW_W'(1);
            end else begin
                col <= col_cur + COL_W'(1);
                row <= row_cur;
            end
        end else begin
            col <= col_cur;
            row <= row_cur;
        end
    end

    // ---------------- S1: products ----------------
    logic [NS-1:0][GRAD_WIDTH-1:0] op_a, op_b;
    logic [NS-1:0][PW-1:0]         prod, s1_prod;
    logic [COL_W-1:0]              s1_col;
    logic [ROW_W-1:0]              s1_row;
    logic                          s1_vld;

    always_comb begin
        op_a = {grad_y, grad_x, grad_x, grad_y, grad_x};
        op_b = {grad_t, grad_t, grad_y, grad_y, grad_x};
    end

    always_ff @(posedge clk) begin
        if (rst) s1_vld <= 1'b0;
        else     s1_vld <= grad_valid;
    end

    always_ff @(posedge clk) begin
        if (grad_valid) begin
            s1_prod <= prod;
            s1_col  <= col_cur;
            s1_row  <= row_cur;
        end
    end

    // ---------------- S2: accumulate ----------------
    logic [TX_W-1:0] s1_tx;
    logic [TY_W-1:0] s1_ty;
    logic            first_px, last_px, s2_go, last_tile;
    sums_t           acc_mem [TILES_X];
    sums_t           acc_rd, base, sum_new, wr_sum, out_sum;
    logic [TX_W-1:0] wr_tx;
    logic            wr_en, fwd_hit;

    assign s1_tx     = s1_col[TB +: TX_W];
    assign s1_ty     = s1_row[TB +: TY_W];
    assign first_px  = (s1_col[TB-1:0] == '0) && (s1_row[TB-1:0] == '0);
    assign last_px   = (&s1_col[TB-1:0]) && (&s1_row[TB-1:0]);
    assign last_tile = (s1_tx == TX_W'(TILES_X-1)) && (s1_ty == TY_W'(TILES_Y-1));
    // frame_sync kills the beat sitting in S1.
    assign s2_go     = s1_vld && !frame_sync;

    assign acc_rd  = acc_mem[s1_tx];
    assign fwd_hit = wr_en && (wr_tx == s1_tx);
    assign base    = fwd_hit ? wr_sum : acc_rd;

    for (genvar i = 0; i < NS; i++) begin : g_lane
        logic [ACC_WIDTH-1:0] ext;
        assign prod[i] = {{GRAD_WIDTH{op_a[i][GRAD_WIDTH-1]}}, op_a[i]}
                       * {{GRAD_WIDTH{op_b[i][GRAD_WIDTH-1]}}, op_b[i]};
        assign ext        = {{(ACC_WIDTH-PW){s1_prod[i][PW-1]}}, s1_prod[i]};
        // The first pixel of a tile loads, so stale contents never need clearing.
        assign sum_new[i] = first_px ? ext : base[i] + ext;
    end

    always_ff @(posedge clk) begin
        if (rst) wr_en <= 1'b0;
        else     wr_en <= s2_go;
    end

    always_ff @(posedge clk) begin
        if (s2_go) begin
            wr_tx  <= s1_tx;
            wr_sum <= sum_new;
        end
        if (wr_en) acc_mem[wr_tx] <= wr_sum;
    end

    // ---------------- record output ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum    <= '0;
            tile_x     <= '0;
            tile_y     <= '0;
            tile_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tile_valid <= s2_go && last_px;
            frame_done <= s2_go && last_px && last_tile;
            if (s2_go && last_px) begin
                out_sum <= sum_new;
                tile_x  <= s1_tx;
                tile_y  <= s1_ty;
            end
        end
    end

    assign sum_xx = out_sum[0];
    assign sum_yy = out_sum[1];
    assign sum_xy = out_sum[2];
    assign sum_xt = out_sum[3];
    assign sum_yt = out_sum[4];

endmodule
